alu_issue: RTL and testbench

Initiator side of the ALU interface. It accepts one R-type execute request at a time through a valid/ready handshake and decodes the MIPS funct field into an ALU opcode. It drives the combinational ALU from registered operands, captures the result and flags, and returns them through a valid/ready response channel. It sits between the multicycle control path and the ALU, and it owns the overflow-trap decision: signed ops trap, unsigned ops do not.

---
 rtl/cpu_types_pkg.sv | 36 +++
 rtl/alu_funct_decode.sv | 36 +++
 rtl/alu_issue.sv | 144 ++++++++++++++
 tb/tb_alu_issue.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU word, ALU opcode and MIPS funct definitions.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_NOR  = 4'd3,
    ALU_ADD  = 4'd4,
    ALU_SUB  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9
  } aluop_t;

  typedef logic [5:0] funct_t;

  localparam funct_t FUNCT_SLL  = 6'h00;
  localparam funct_t FUNCT_SRL  = 6'h02;
  localparam funct_t FUNCT_ADD  = 6'h20;
  localparam funct_t FUNCT_ADDU = 6'h21;
  localparam funct_t FUNCT_SUB  = 6'h22;
  localparam funct_t FUNCT_SUBU = 6'h23;
  localparam funct_t FUNCT_AND  = 6'h24;
  localparam funct_t FUNCT_OR   = 6'h25;
  localparam funct_t FUNCT_XOR  = 6'h26;
  localparam funct_t FUNCT_NOR  = 6'h27;
  localparam funct_t FUNCT_SLT  = 6'h2A;
  localparam funct_t FUNCT_SLTU = 6'h2B;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decoder: opcode, shift operand routing,
// overflow-trap enable and illegal-funct detection.
module alu_funct_decode
  import cpu_types_pkg::*;
(
  input  funct_t funct,
  output aluop_t aluop,
  output logic   is_shift,
  output logic   trap_en,
  output logic   illegal
);

  // Unrecognised functs fall through to a quiet AND with the illegal bit set.
  always_comb begin
    aluop    = ALU_AND;
    is_shift = 1'b0;
    trap_en  = 1'b0;
    illegal  = 1'b0;
    case (funct)
      FUNCT_SLL:  begin aluop = ALU_SLL; is_shift = 1'b1; end
      FUNCT_SRL:  begin aluop = ALU_SRL; is_shift = 1'b1; end
      FUNCT_ADD:  begin aluop = ALU_ADD; trap_en = 1'b1; end
      FUNCT_ADDU: aluop = ALU_ADD;
      FUNCT_SUB:  begin aluop = ALU_SUB; trap_en = 1'b1; end
      FUNCT_SUBU: aluop = ALU_SUB;
      FUNCT_AND:  aluop = ALU_AND;
      FUNCT_OR:   aluop = ALU_OR;
      FUNCT_XOR:  aluop = ALU_XOR;
      FUNCT_NOR:  aluop = ALU_NOR;
      FUNCT_SLT:  aluop = ALU_SLT;
      FUNCT_SLTU: aluop = ALU_SLTU;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts one R-type request, drives the external ALU
// from registered operands for one cycle, and returns the captured result.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// EXEC  | ALU driven from operand registers, result captured at cycle end
// RESP  | rsp_valid=1, response held until rsp_ready
module alu_issue
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [4:0]  req_shamt,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_zero,
  output logic        rsp_negative,
  output logic        rsp_illegal,
  output aluop_t      alu_aluop,
  output logic [31:0] alu_port_a,
  output logic [31:0] alu_port_b,
  input  logic [31:0] alu_port_o,
  input  logic        alu_flag_overflow,
  input  logic        alu_flag_zero,
  input  logic        alu_flag_negative
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;

  aluop_t      dec_aluop;
  logic        dec_is_shift;
  logic        dec_trap_en;
  logic        dec_illegal;

  logic [31:0] sel_a;
  logic [31:0] sel_b;

  aluop_t      aluop_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        trap_en_q;
  logic        illegal_q;

  alu_funct_decode u_decode (
    .funct    (req_funct),
    .aluop    (dec_aluop),
    .is_shift (dec_is_shift),
    .trap_en  (dec_trap_en),
    .illegal  (dec_illegal)
  );

  // Operand routing at request time; illegal requests carry zero operands.
  always_comb begin
    sel_a = req_rs;
    sel_b = req_rt;
    if (dec_illegal) begin
      sel_a = '0;
      sel_b = '0;
    end else if (dec_is_shift) begin
      sel_a = req_rt;
      sel_b = {27'b0, req_shamt};
    end
  end

  // Handshake flags depend only on state.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // ALU sees real operands only in EXEC so its outputs stay quiet otherwise.
  always_comb begin
    alu_aluop  = ALU_AND;
    alu_port_a = '0;
    alu_port_b = '0;
    if (state == EXEC) begin
      alu_aluop  = aluop_q;
      alu_port_a = a_q;
      alu_port_b = b_q;
    end
  end

  // FSM, operand capture on accept and response capture at end of EXEC.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      aluop_q      <= ALU_AND;
      a_q          <= '0;
      b_q          <= '0;
      trap_en_q    <= 1'b0;
      illegal_q    <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_negative <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            aluop_q   <= dec_aluop;
            a_q       <= sel_a;
            b_q       <= sel_b;
            trap_en_q <= dec_trap_en;
            illegal_q <= dec_illegal;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (illegal_q) begin
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b1;
            rsp_negative <= 1'b0;
            rsp_illegal  <= 1'b1;
          end else begin
            rsp_result   <= alu_port_o;
            rsp_overflow <= alu_flag_overflow & trap_en_q;
            rsp_zero     <= alu_flag_zero;
            rsp_negative <= alu_flag_negative;
            rsp_illegal  <= 1'b0;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU, funct-level reference model,
// directed vectors, randomized traffic and reset cases.
module tb_alu_issue;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [4:0]  req_shamt;
  logic [31:0] req_rs;
  logic [31:0] req_rt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_zero;
  logic        rsp_negative;
  logic        rsp_illegal;
  aluop_t      alu_aluop;
  logic [31:0] alu_port_a;
  logic [31:0] alu_port_b;
  logic [31:0] alu_port_o;
  logic        alu_flag_overflow;
  logic        alu_flag_zero;
  logic        alu_flag_negative;

  alu_issue dut (
    .CLK               (CLK),
    .RST               (RST),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_funct         (req_funct),
    .req_shamt         (req_shamt),
    .req_rs            (req_rs),
    .req_rt            (req_rt),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_result        (rsp_result),
    .rsp_overflow      (rsp_overflow),
    .rsp_zero          (rsp_zero),
    .rsp_negative      (rsp_negative),
    .rsp_illegal       (rsp_illegal),
    .alu_aluop         (alu_aluop),
    .alu_port_a        (alu_port_a),
    .alu_port_b        (alu_port_b),
    .alu_port_o        (alu_port_o),
    .alu_flag_overflow (alu_flag_overflow),
    .alu_flag_zero     (alu_flag_zero),
    .alu_flag_negative (alu_flag_negative)
  );

  always #5 CLK = ~CLK;

  // Behavioural combinational ALU; overflow is signed overflow for ADD/SUB.
  logic [31:0] alu_sum;
  logic [31:0] alu_dif;
  assign alu_sum = alu_port_a + alu_port_b;
  assign alu_dif = alu_port_a - alu_port_b;

  always_comb begin
    alu_port_o        = '0;
    alu_flag_overflow = 1'b0;
    case (alu_aluop)
      ALU_AND:  alu_port_o = alu_port_a & alu_port_b;
      ALU_OR:   alu_port_o = alu_port_a | alu_port_b;
      ALU_XOR:  alu_port_o = alu_port_a ^ alu_port_b;
      ALU_NOR:  alu_port_o = ~(alu_port_a | alu_port_b);
      ALU_ADD: begin
        alu_port_o        = alu_sum;
        alu_flag_overflow = (alu_port_a[31] == alu_port_b[31]) && (alu_sum[31] != alu_port_a[31]);
      end
      ALU_SUB: begin
        alu_port_o        = alu_dif;
        alu_flag_overflow = (alu_port_a[31] != alu_port_b[31]) && (alu_dif[31] != alu_port_a[31]);
      end
      ALU_SLT:  alu_port_o = {31'b0, $signed(alu_port_a) < $signed(alu_port_b)};
      ALU_SLTU: alu_port_o = {31'b0, alu_port_a < alu_port_b};
      ALU_SLL:  alu_port_o = alu_port_a << alu_port_b[4:0];
      ALU_SRL:  alu_port_o = alu_port_a >> alu_port_b[4:0];
      default:  alu_port_o = '0;
    endcase
  end
  assign alu_flag_zero     = (alu_port_o == 32'h0);
  assign alu_flag_negative = alu_port_o[31];

  typedef struct {
    logic [31:0] result;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } exp_t;

  // MIPS-level reference: what the response and EXEC-cycle ALU drive must be.
  function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [31:0] r;
    r     = '0;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    e.a   = rs;
    e.b   = rt;
    e.op  = 4'(ALU_AND);
    case (f)
      6'h00: begin r = rt << sh; e.a = rt; e.b = {27'b0, sh}; e.op = 4'(ALU_SLL); end
      6'h02: begin r = rt >> sh; e.a = rt; e.b = {27'b0, sh}; e.op = 4'(ALU_SRL); end
      6'h20, 6'h21: begin
        r = rs + rt;
        e.op = 4'(ALU_ADD);
        if (f == 6'h20) e.ovf = (rs[31] == rt[31]) && (r[31] != rs[31]);
      end
      6'h22, 6'h23: begin
        r = rs - rt;
        e.op = 4'(ALU_SUB);
        if (f == 6'h22) e.ovf = (rs[31] != rt[31]) && (r[31] != rs[31]);
      end
      6'h24: r = rs & rt;
      6'h25: begin r = rs | rt; e.op = 4'(ALU_OR); end
      6'h26: begin r = rs ^ rt; e.op = 4'(ALU_XOR); end
      6'h27: begin r = ~(rs | rt); e.op = 4'(ALU_NOR); end
      6'h2A: begin r = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; e.op = 4'(ALU_SLT); end
      6'h2B: begin r = (rs < rt) ? 32'd1 : 32'd0; e.op = 4'(ALU_SLTU); end
      default: begin e.ill = 1'b1; e.a = '0; e.b = '0; end
    endcase
    e.result = r;
    e.zero   = (r == 32'h0);
    e.neg    = r[31];
    return e;
  endfunction

  int   checks = 0;
  int   errors = 0;
  exp_t exp_cur;
  bit   exp_valid = 1'b0;
  bit   exp_exec  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle compare: held response vs model, and quiet ALU outside EXEC.
  always @(negedge CLK) begin
    if (!RST) begin
      if (rsp_valid) begin
        if (!exp_valid) begin
          chk("rsp_valid_unexpected", {31'b0, rsp_valid}, {31'b0, exp_valid});
        end else begin
          chk("rsp_result",   rsp_result,            exp_cur.result);
          chk("rsp_overflow", {31'b0, rsp_overflow}, {31'b0, exp_cur.ovf});
          chk("rsp_zero",     {31'b0, rsp_zero},     {31'b0, exp_cur.zero});
          chk("rsp_negative", {31'b0, rsp_negative}, {31'b0, exp_cur.neg});
          chk("rsp_illegal",  {31'b0, rsp_illegal},  {31'b0, exp_cur.ill});
        end
      end
      if (!exp_exec) begin
        chk("alu_quiet_op", {28'b0, alu_aluop}, {28'b0, 4'(ALU_AND)});
        chk("alu_quiet_a",  alu_port_a, 32'h0);
        chk("alu_quiet_b",  alu_port_b, 32'h0);
      end
    end
  end

  // One transaction; hold = cycles of rsp_ready=0 backpressure in RESP.
  task automatic run_txn(input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt, input int hold);
    exp_t e;
    e = model(f, sh, rs, rt);
    req_funct = f;
    req_shamt = sh;
    req_rs    = rs;
    req_rt    = rt;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_funct = 6'($urandom);
    req_shamt = 5'($urandom);
    req_rs    = $urandom;
    req_rt    = $urandom;
    exp_cur   = e;
    exp_valid = 1'b1;
    exp_exec  = 1'b1;
    chk("exec_req_ready", {31'b0, req_ready}, 32'd0);
    chk("exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("exec_alu_op", {28'b0, alu_aluop}, {28'b0, e.op});
    chk("exec_alu_a", alu_port_a, e.a);
    chk("exec_alu_b", alu_port_b, e.b);
    @(posedge CLK);
    #1;
    exp_exec = 1'b0;
    chk("latency_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("resp_req_ready", {31'b0, req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK);
      #1;
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    exp_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("done_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  logic [5:0] funct_tab [16] = '{6'h00, 6'h02, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h01, 6'h3F, 6'h2C};
  logic [31:0] corner_tab [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h5};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 2) == 0) return corner_tab[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  exp_t pin;

  initial begin
    RST       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_funct = '0;
    req_shamt = '0;
    req_rs    = '0;
    req_rt    = '0;

    // Pin the reference model against hand-computed values.
    pin = model(6'h20, 5'd0, 32'h7FFFFFFF, 32'h1);
    chk("pin_add_result", pin.result, 32'h80000000);
    chk("pin_add_ovf", {31'b0, pin.ovf}, 32'd1);
    pin = model(6'h21, 5'd0, 32'h7FFFFFFF, 32'h1);
    chk("pin_addu_ovf", {31'b0, pin.ovf}, 32'd0);
    pin = model(6'h22, 5'd0, 32'h80000000, 32'h1);
    chk("pin_sub_result", pin.result, 32'h7FFFFFFF);
    chk("pin_sub_ovf", {31'b0, pin.ovf}, 32'd1);
    pin = model(6'h00, 5'd31, 32'hDEADBEEF, 32'h1);
    chk("pin_sll_result", pin.result, 32'h80000000);
    pin = model(6'h02, 5'd4, 32'h0, 32'h80000000);
    chk("pin_srl_result", pin.result, 32'h08000000);
    pin = model(6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1);
    chk("pin_slt_result", pin.result, 32'h1);
    pin = model(6'h2B, 5'd0, 32'hFFFFFFFF, 32'h1);
    chk("pin_sltu_result", pin.result, 32'h0);
    pin = model(6'h08, 5'd3, 32'h12345678, 32'h9);
    chk("pin_illegal_zero", {31'b0, pin.zero}, 32'd1);

    // Reset state, sampled in the cycle after a reset edge.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_rsp_flags", {27'b0, rsp_overflow, rsp_zero, rsp_negative, rsp_illegal, 1'b0}, 32'd0);
    chk("rst_alu_op", {28'b0, alu_aluop}, {28'b0, 4'(ALU_AND)});
    chk("rst_alu_a", alu_port_a, 32'h0);
    chk("rst_alu_b", alu_port_b, 32'h0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Directed vectors.
    run_txn(6'h20, 5'd0,  32'h7FFFFFFF, 32'h00000001, 0);
    run_txn(6'h21, 5'd0,  32'h7FFFFFFF, 32'h00000001, 1);
    run_txn(6'h22, 5'd0,  32'h80000000, 32'h00000001, 0);
    run_txn(6'h23, 5'd0,  32'h00000005, 32'h00000005, 2);
    run_txn(6'h00, 5'd31, 32'hDEADBEEF, 32'h00000001, 0);
    run_txn(6'h02, 5'd4,  32'hDEADBEEF, 32'h80000000, 0);
    run_txn(6'h2A, 5'd0,  32'hFFFFFFFF, 32'h00000001, 0);
    run_txn(6'h2B, 5'd0,  32'hFFFFFFFF, 32'h00000001, 0);
    run_txn(6'h27, 5'd0,  32'h0F0F0000, 32'h000000F0, 0);
    run_txn(6'h20, 5'd0,  32'h80000000, 32'h80000000, 5);
    run_txn(6'h08, 5'd7,  32'hFFFFFFFF, 32'hFFFFFFFF, 1);

    // Reset during EXEC discards the transaction.
    req_funct = 6'h20;
    req_rs    = 32'h11111111;
    req_rt    = 32'h22222222;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    exp_exec  = 1'b1;
    RST       = 1'b1;
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    exp_exec = 1'b0;
    chk("rst_exec_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_exec_rsp_result", rsp_result, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      chk("rst_exec_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end

    // Reset in the same cycle as req_valid: request not accepted.
    req_valid = 1'b1;
    RST       = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    RST       = 1'b0;
    chk("rst_req_not_taken", {31'b0, req_ready}, 32'd1);
    @(posedge CLK);
    #1;
    chk("rst_req_still_idle", {31'b0, req_ready}, 32'd1);
    chk("rst_req_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      run_txn(funct_tab[$urandom_range(0, 15)], 5'($urandom), pick_operand(), pick_operand(),
              int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
